// File: rtl/or_bit.sv
// ----------------------------------------------------------------------------
// or_bit
// ----------------------------------------------------------------------------
// Bitwise OR functional unit of the ALU datapath.
//
// The primary output is purely combinational so the ALU result mux can consume
// it in the same cycle as the operands arrive. A registered copy is provided
// for pipelined consumers. Clock and reset only touch that registered copy.
//
// Parameters
//   WIDTH     operand/result bit width (must be >= 1)
//
// Ports
//   clk       in   1      rising-edge clock, drives result_q only
//   rst_n     in   1      asynchronous active-low reset, clears result_q only
//   operandA  in   WIDTH  first operand
//   operandB  in   WIDTH  second operand
//   result    out  WIDTH  operandA | operandB, combinational, zero latency
//   result_q  out  WIDTH  result registered on the rising edge of clk
//
// Handshake: none. Operands are sampled continuously; there is no valid/ready
// pair, and result_q simply follows result with one cycle of latency.
// ----------------------------------------------------------------------------
module or_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q
);

    // Plain per-bit OR: no carries, no inter-bit dependence. Standard | keeps
    // the 4-state behaviour (a 1 on either side dominates, otherwise X flows).
    assign result = operandA | operandB;

    // The only state in the block. Reset is asynchronous so result_q drops to
    // zero as soon as rst_n falls, and stays there until the first rising edge
    // after rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_or_bit.sv
// ----------------------------------------------------------------------------
// tb_or_bit
// ----------------------------------------------------------------------------
// Directed bench for or_bit: combinational identities, complement, all-ones,
// zero, X handling, a long operand sweep with the clock stopped, and the
// registered path including asynchronous reset behaviour.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_or_bit;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         clk_run;
    logic         rst_n;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] result;
    logic [W-1:0] result_q;

    int checks;
    int errors;
    int sweep_pass;
    int sweep_total;

    // Clock only toggles while clk_run is set, so the long sweep costs no cycles.
    initial begin
        clk = 1'b0;
        forever begin
            wait (clk_run);
            #5 clk = ~clk;
        end
    end

    or_bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .operandA (operandA),
        .operandB (operandB),
        .result   (result),
        .result_q (result_q)
    );

    // ---------------- driver / check tasks ----------------
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        operandA = a;
        operandB = b;
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] b_ref;
        logic [W-1:0] exp_v;
        checks      = 0;
        errors      = 0;
        sweep_pass  = 0;
        sweep_total = 0;
        clk_run     = 1'b0;
        rst_n       = 1'b0;
        operandA    = '0;
        operandB    = '0;
        #2;

        // Reset state: register cleared, combinational path valid under reset.
        check("reset_result_q", result_q, 32'h0000_0000);
        check("reset_result",   result,   32'h0000_0000);
        drive(32'h0000_00F0, 32'h0000_000F);
        check("result_in_reset",   result,   32'h0000_00FF);
        check("result_q_in_reset", result_q, 32'h0000_0000);

        // Directed combinational vectors.
        b_ref = 32'hCA8C_F1C5;
        drive(32'h0000_0000, b_ref);
        check("identity",    result, 32'hCA8C_F1C5);
        drive(32'h0000_0002, b_ref);
        check("a_eq_2",      result, 32'hCA8C_F1C7);
        drive(32'h3573_0E3A, b_ref);
        check("complement",  result, 32'hFFFF_FFFF);
        drive(b_ref, b_ref);
        check("idempotent",  result, 32'hCA8C_F1C5);
        drive(32'hFFFF_FFFF, 32'h1234_5678);
        check("all_ones_a",  result, 32'hFFFF_FFFF);
        drive(32'h1234_5678, 32'hFFFF_FFFF);
        check("all_ones_b",  result, 32'hFFFF_FFFF);
        drive(32'h0000_0000, 32'h0000_0000);
        check("zero",        result, 32'h0000_0000);
        drive(32'h8000_0000, 32'h0000_0001);
        check("edge_bits",   result, 32'h8000_0001);
        drive(32'hA5A5_0000, 32'h0000_5A5A);
        check("disjoint",    result, 32'hA5A5_5A5A);

        // X handling: a 1 dominates, a 0 lets X through.
        drive(32'h0000_FFFF, 32'hxxxx_xxxx);
        check("x_dominated", result, 32'hxxxx_FFFF);

        // Sweep A with B fixed, clock stopped; 100% of vectors must match.
        for (int a = 0; a <= 429495; a++) begin
            operandA = a[W-1:0];
            operandB = b_ref;
            #20;
            exp_v = a[W-1:0] | b_ref;
            sweep_total++;
            if (result === exp_v) begin
                sweep_pass++;
            end else begin
                checks++;
                errors++;
                $error("FAIL sweep a=%0d: observed=%h expected=%h", a, result, exp_v);
            end
        end
        check("sweep_pass_count", sweep_pass, 32'd429496);

        // Registered path. Still in reset: edges must not load.
        clk_run = 1'b1;
        drive(32'h0000_0055, 32'h0000_00AA);
        tick();
        check("q_held_in_reset", result_q, 32'h0000_0000);

        // Release and load on the first edge.
        rst_n = 1'b1;
        drive(32'h0000_0001, 32'h0000_0010);
        check("q_before_edge", result_q, 32'h0000_0000);
        tick();
        check("q_after_edge", result_q, 32'h0000_0011);
        drive(32'hDEAD_0000, 32'h0000_BEEF);
        check("q_latency_1", result_q, 32'h0000_0011);
        tick();
        check("q_next", result_q, 32'hDEAD_BEEF);

        // Mid-operation async reset: clears at once, away from any edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("q_async_clear", result_q, 32'h0000_0000);
        check("result_during_reset", result, 32'hDEAD_BEEF);

        // Release away from an edge: stays 0 until the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0000_0001, 32'h0000_0010);
        check("q_after_release", result_q, 32'h0000_0000);
        tick();
        check("q_first_edge", result_q, 32'h0000_0011);

        clk_run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
